// File: rtl/psram_rsp_pkg.sv
// Shared types and defaults for the OPI PSRAM responder.
package psram_rsp_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 8;

  localparam logic [7:0] RD_CMD_DEF = 8'h20;
  localparam logic [7:0] WR_CMD_DEF = 8'hA0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WAIT,
    ST_RDATA,
    ST_WDATA,
    ST_DROP
  } state_e;

  // Registered pin drive towards the controller.
  typedef struct packed {
    logic [7:0] io;
    logic       io_oe;
    logic       dqs;
    logic       dqs_oe;
  } drv_t;

  // True when the opcode is one of the two supported burst commands.
  function automatic logic op_valid(input logic [7:0] op,
                                    input logic [7:0] rd_op,
                                    input logic [7:0] wr_op);
    return (op == rd_op) || (op == wr_op);
  endfunction

endpackage

// File: rtl/psram_rsp_if.sv
// PSRAM pin bundle; names are from the responder's point of view.
interface psram_rsp_if;

  logic       psram_sck_i;
  logic       psram_ce_i;
  logic [7:0] psram_io_i;
  logic [7:0] psram_io_en_i;
  logic       psram_dqs_i;
  logic [7:0] psram_io_o;
  logic       psram_io_oe_o;
  logic       psram_dqs_o;
  logic       psram_dqs_oe_o;

  modport slave (
    input  psram_sck_i, psram_ce_i, psram_io_i, psram_io_en_i, psram_dqs_i,
    output psram_io_o, psram_io_oe_o, psram_dqs_o, psram_dqs_oe_o
  );

  modport master (
    output psram_sck_i, psram_ce_i, psram_io_i, psram_io_en_i, psram_dqs_i,
    input  psram_io_o, psram_io_oe_o, psram_dqs_o, psram_dqs_oe_o
  );

endinterface

// File: rtl/psram_rsp_mem.sv
// Byte array backing the responder: synchronous write, combinational read.
module psram_rsp_mem #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [7:0]               wdata_i,
  output logic [7:0]               rdata_o
);

  logic [7:0] mem_q [DEPTH];

  // Write port; contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/psram_rsp.sv
// OPI PSRAM responder: decodes DDR command/address phases sampled on clk_i
// and serves linear burst reads/writes from an internal byte array.
module psram_rsp
  import psram_rsp_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter logic [7:0]  RD_CMD = RD_CMD_DEF,
  parameter logic [7:0]  WR_CMD = WR_CMD_DEF,
  parameter int unsigned WAIT   = 5
) (
  input  logic         clk_i,
  input  logic         rst_i,
  psram_rsp_if.slave   pins,
  output logic         busy_o,
  output logic         err_o
);

  localparam int unsigned MEM_AW = $clog2(DEPTH);

  logic              sck_q;
  state_e            state_q, state_d;
  logic [7:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  drv_t              drv_q, drv_d;
  logic              busy_q;
  logic              err_q, err_d;

  logic              rise_c, fall_c, edge_c;
  logic              mem_we_c;
  logic [7:0]        mem_rdata_c;

  assign rise_c = pins.psram_sck_i & ~sck_q;
  assign fall_c = ~pins.psram_sck_i & sck_q;
  assign edge_c = rise_c | fall_c;

  psram_rsp_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (mem_we_c & ~rst_i),
    .addr_i  (addr_q[MEM_AW-1:0]),
    .wdata_i (pins.psram_io_i),
    .rdata_o (mem_rdata_c)
  );

  // State, counters and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_q   <= 1'b0;
      state_q <= ST_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      drv_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sck_q   <= pins.psram_sck_i;
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      drv_q   <= drv_d;
      busy_q  <= (state_d != ST_IDLE);
      err_q   <= err_d;
    end
  end

  // Phase decoding, address/wait counting and pin drive.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    drv_d    = drv_q;
    err_d    = 1'b0;
    mem_we_c = 1'b0;

    if (pins.psram_ce_i) begin
      // Deselect truncates any burst silently.
      state_d = ST_IDLE;
      op_d    = '0;
      addr_d  = '0;
      cnt_d   = '0;
      drv_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_CMD;
          cnt_d   = '0;
        end
        ST_CMD: begin
          if (rise_c) begin
            op_d = pins.psram_io_i;
          end else if (fall_c) begin
            if ((pins.psram_io_i != op_q) || !op_valid(op_q, RD_CMD, WR_CMD)) begin
              err_d   = 1'b1;
              state_d = ST_DROP;
            end else begin
              state_d = ST_ADDR;
              cnt_d   = '0;
            end
          end
        end
        ST_ADDR: begin
          if (edge_c) begin
            addr_d = {addr_q[ADDR_W-9:0], pins.psram_io_i};
            if (cnt_q == CNT_W'(3)) begin
              state_d = ST_WAIT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_WAIT: begin
          if (fall_c) begin
            if (cnt_q == CNT_W'(WAIT - 1)) begin
              state_d = (op_q == RD_CMD) ? ST_RDATA : ST_WDATA;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_RDATA: begin
          if (edge_c) begin
            drv_d.io     = mem_rdata_c;
            drv_d.dqs    = rise_c;
            drv_d.io_oe  = 1'b1;
            drv_d.dqs_oe = 1'b1;
            addr_d       = addr_q + ADDR_W'(1);
          end
        end
        ST_WDATA: begin
          if (edge_c) begin
            mem_we_c = ~pins.psram_dqs_i;
            addr_d   = addr_q + ADDR_W'(1);
          end
        end
        ST_DROP: begin
          state_d = ST_DROP;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Both ends driving DQ at once.
    if (drv_q.io_oe && (pins.psram_io_en_i != 8'h00)) begin
      err_d = 1'b1;
    end
  end

  assign pins.psram_io_o     = drv_q.io;
  assign pins.psram_io_oe_o  = drv_q.io_oe;
  assign pins.psram_dqs_o    = drv_q.dqs;
  assign pins.psram_dqs_oe_o = drv_q.dqs_oe;
  assign busy_o              = busy_q;
  assign err_o               = err_q;

endmodule
